// File: rtl/ram_read_sweeper.sv
// ram_read_sweeper: steps the read address of a small synchronous RAM on a
// programmable tick, waits out the RAM read latency and then latches the
// aligned (address, data) pair for the seven-segment display stage.
// Optional feature macro: SWEEP_MANUAL_EN adds a manual address override
// (ports manual / manual_addr). Without it the sweep is purely automatic.
module ram_read_sweeper #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 4,
  parameter int TICK_COUNT   = 50000000,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef SWEEP_MANUAL_EN
  input  logic                  manual,
  input  logic [ADDR_WIDTH-1:0] manual_addr,
`endif
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  step,
  output logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid
);

  localparam int DIV_W = (TICK_COUNT > 2) ? $clog2(TICK_COUNT) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_COUNT - 1);
  // Counter value seen on the edge that completes the read latency.
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DIV_W-1:0]      r_div;
  logic                  r_step;
  logic [0:0]            r_state;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [ADDR_WIDTH-1:0] r_disp_addr;
  logic [DATA_WIDTH-1:0] r_disp_data;
  logic                  r_disp_valid;

  logic                  w_manual;
  logic [ADDR_WIDTH-1:0] w_manual_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [DIV_W-1:0]      w_next_div;
  logic                  w_next_step;
  logic                  w_addr_chg;

`ifdef SWEEP_MANUAL_EN
  assign w_manual      = manual;
  assign w_manual_addr = manual_addr;
`else
  assign w_manual      = 1'b0;
  assign w_manual_addr = {ADDR_WIDTH{1'b0}};
`endif

  // Next address / divider / step: manual override holds the divider,
  // otherwise the divider rolls over once per TICK_COUNT edges.
  always_comb begin
    w_next_addr = r_rd_addr;
    w_next_div  = r_div + DIV_W'(1);
    w_next_step = 1'b0;
    if (w_manual) begin
      w_next_addr = w_manual_addr;
      w_next_div  = {DIV_W{1'b0}};
      w_next_step = 1'b0;
    end else if (r_div == DIV_LAST) begin
      w_next_addr = r_rd_addr + ADDR_WIDTH'(1);
      w_next_div  = {DIV_W{1'b0}};
      w_next_step = 1'b1;
    end else begin
      w_next_addr = r_rd_addr;
      w_next_div  = r_div + DIV_W'(1);
      w_next_step = 1'b0;
    end
  end

  // Any edge that moves rd_addr (auto step or manual) starts a new read.
  assign w_addr_chg = (w_next_addr != r_rd_addr);

  // Address, divider and step pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= {ADDR_WIDTH{1'b0}};
      r_div     <= {DIV_W{1'b0}};
      r_step    <= 1'b0;
    end else begin
      r_rd_addr <= w_next_addr;
      r_div     <= w_next_div;
      r_step    <= w_next_step;
    end
  end

  // Read-latency FSM and display capture. The latency counter holds the
  // number of edges elapsed since rd_addr was set; reset release counts as
  // setting address 0. A new address always wins over a pending capture so
  // a stale word is never tagged with the new address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_READ;
      r_lat_cnt    <= {LAT_W{1'b0}};
      r_disp_addr  <= {ADDR_WIDTH{1'b0}};
      r_disp_data  <= {DATA_WIDTH{1'b0}};
      r_disp_valid <= 1'b0;
    end else if (w_addr_chg) begin
      r_state   <= S_READ;
      r_lat_cnt <= {LAT_W{1'b0}};
    end else begin
      case (r_state)
        S_READ: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_disp_addr  <= r_rd_addr;
            r_disp_data  <= rd_data;
            r_disp_valid <= 1'b1;
            r_lat_cnt    <= {LAT_W{1'b0}};
            r_state      <= S_WAIT;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        S_WAIT: begin
          r_state <= S_WAIT;
        end
        default: begin
          r_state   <= S_WAIT;
          r_lat_cnt <= {LAT_W{1'b0}};
        end
      endcase
    end
  end

  assign rd_addr    = r_rd_addr;
  assign step       = r_step;
  assign disp_addr  = r_disp_addr;
  assign disp_data  = r_disp_data;
  assign disp_valid = r_disp_valid;

endmodule

// File: tb/tb_ram_read_sweeper.sv
// Self-checking bench for ram_read_sweeper with TICK_COUNT=4, READ_LATENCY=2.
module tb_ram_read_sweeper;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int TICK = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          step;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
`ifdef SWEEP_MANUAL_EN
  logic          manual = 1'b0;
  logic [AW-1:0] manual_addr = '0;
`endif

  int checks = 0;
  int errors = 0;
  int n = 0;            // edges since the last reset release
  bit saw_stale;

  ram_read_sweeper #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TICK_COUNT(TICK), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef SWEEP_MANUAL_EN
    .manual(manual),
    .manual_addr(manual_addr),
`endif
    .rd_data(rd_data),
    .rd_addr(rd_addr),
    .step(step),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  // RAM model: rd_addr is the address register, the array adds the output
  // register, so the word for an address set at edge E is sampled at E+2.
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    logic [DW-1:0] lo;
    lo = a[DW-1:0];
    return lo ^ 4'hA;
  endfunction

  always @(posedge clk) rd_data <= mem(rd_addr);

  typedef struct {
    int            n;
    logic [AW-1:0] addr;
    logic          stp;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata;
    logic          dvalid;
  } vec_t;

  // Reference: address k is set at edge k*TICK and captured LAT edges later.
  function automatic vec_t model(input int e);
    vec_t v;
    int k;
    v.n    = e;
    v.addr = AW'((e / TICK) % 32);
    v.stp  = (e > 0) && (e % TICK == 0);
    if (e < LAT) begin
      v.daddr = '0; v.ddata = '0; v.dvalid = 1'b0;
    end else begin
      k = (e - LAT) / TICK;
      v.daddr  = AW'(k % 32);
      v.ddata  = mem(AW'(k % 32));
      v.dvalid = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(v.addr));
    chk({tag, ".step"}, 32'(step), 32'(v.stp));
    chk({tag, ".disp_addr"}, 32'(disp_addr), 32'(v.daddr));
    chk({tag, ".disp_data"}, 32'(disp_data), 32'(v.ddata));
    chk({tag, ".disp_valid"}, 32'(disp_valid), 32'(v.dvalid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Hold reset for 'hold' edges, release between edges; n=0 afterwards.
  task automatic do_reset(input int hold);
    reset = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    reset = 1'b0;
    n = 0;
  endtask

  task automatic run_model(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk_vec(tag, model(n));
    end
  endtask

  vec_t tbl[15];

  initial begin
    // Expected values written straight from the sweep rules.
    tbl[0]  = '{n: 0,   addr: 5'd0,  stp: 1'b0, daddr: 5'd0,  ddata: 4'h0, dvalid: 1'b0};
    tbl[1]  = '{n: 1,   addr: 5'd0,  stp: 1'b0, daddr: 5'd0,  ddata: 4'h0, dvalid: 1'b0};
    tbl[2]  = '{n: 2,   addr: 5'd0,  stp: 1'b0, daddr: 5'd0,  ddata: 4'hA, dvalid: 1'b1};
    tbl[3]  = '{n: 3,   addr: 5'd0,  stp: 1'b0, daddr: 5'd0,  ddata: 4'hA, dvalid: 1'b1};
    tbl[4]  = '{n: 4,   addr: 5'd1,  stp: 1'b1, daddr: 5'd0,  ddata: 4'hA, dvalid: 1'b1};
    tbl[5]  = '{n: 5,   addr: 5'd1,  stp: 1'b0, daddr: 5'd0,  ddata: 4'hA, dvalid: 1'b1};
    tbl[6]  = '{n: 6,   addr: 5'd1,  stp: 1'b0, daddr: 5'd1,  ddata: 4'hB, dvalid: 1'b1};
    tbl[7]  = '{n: 8,   addr: 5'd2,  stp: 1'b1, daddr: 5'd1,  ddata: 4'hB, dvalid: 1'b1};
    tbl[8]  = '{n: 10,  addr: 5'd2,  stp: 1'b0, daddr: 5'd2,  ddata: 4'h8, dvalid: 1'b1};
    tbl[9]  = '{n: 12,  addr: 5'd3,  stp: 1'b1, daddr: 5'd2,  ddata: 4'h8, dvalid: 1'b1};
    tbl[10] = '{n: 14,  addr: 5'd3,  stp: 1'b0, daddr: 5'd3,  ddata: 4'h9, dvalid: 1'b1};
    tbl[11] = '{n: 124, addr: 5'd31, stp: 1'b1, daddr: 5'd30, ddata: 4'h4, dvalid: 1'b1};
    tbl[12] = '{n: 126, addr: 5'd31, stp: 1'b0, daddr: 5'd31, ddata: 4'h5, dvalid: 1'b1};
    tbl[13] = '{n: 128, addr: 5'd0,  stp: 1'b1, daddr: 5'd31, ddata: 4'h5, dvalid: 1'b1};
    tbl[14] = '{n: 130, addr: 5'd0,  stp: 1'b0, daddr: 5'd0,  ddata: 4'hA, dvalid: 1'b1};

    // Table run: free sweep from reset through the 31->0 wrap.
    do_reset(3);
    for (int i = 0; i < 15; i++) begin
      while (n < tbl[i].n) tick();
      chk_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset while reading address 7: outputs clear with no clock edge.
    do_reset(2);
    run_model(29, "pre7");
    chk("in_read_7.rd_addr", 32'(rd_addr), 32'd7);
    reset = 1'b1;
    #1;
    chk("async.rd_addr", 32'(rd_addr), 32'd0);
    chk("async.disp_addr", 32'(disp_addr), 32'd0);
    chk("async.disp_data", 32'(disp_data), 32'd0);
    chk("async.disp_valid", 32'(disp_valid), 32'd0);
    chk("async.step", 32'(step), 32'd0);
    do_reset(2);
    saw_stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_vec("post7", model(n));
      if (disp_valid && disp_addr == 5'd7) saw_stale = 1'b1;
    end
    chk("no_capture_7", 32'(saw_stale), 32'd0);
    chk("first_cap.disp_addr", 32'(disp_addr), 32'd0);
    chk("first_cap.disp_data", 32'(disp_data), 32'hA);

    // Random run lengths and reset points against the reference model.
    for (int r = 0; r < 6; r++) begin
      do_reset(int'($urandom_range(1, 3)));
      chk_vec("rnd_rel", model(0));
      run_model(int'($urandom_range(1, 150)), $sformatf("rnd%0d", r));
    end

`ifdef SWEEP_MANUAL_EN
    // Manual override: 5 then 9 one edge apart, only 9 is captured.
    manual = 1'b1;
    manual_addr = 5'd5;
    do_reset(2);
    saw_stale = 1'b0;
    tick();
    manual_addr = 5'd9;
    for (int i = 0; i < 19; i++) begin
      tick();
      chk("man.step", 32'(step), 32'd0);
      if (disp_valid && disp_addr == 5'd5) saw_stale = 1'b1;
      if (n == 4) begin
        chk("man.disp_addr", 32'(disp_addr), 32'd9);
        chk("man.disp_data", 32'(disp_data), 32'h3);
        chk("man.disp_valid", 32'(disp_valid), 32'd1);
      end
    end
    chk("man.no_capture_5", 32'(saw_stale), 32'd0);
    // Release manual at address 9: step 4 edges after the last manual edge.
    manual = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("resume.step_low", 32'(step), 32'd0);
      chk("resume.rd_addr9", 32'(rd_addr), 32'd9);
    end
    tick();
    chk("resume.step", 32'(step), 32'd1);
    chk("resume.rd_addr", 32'(rd_addr), 32'd10);
    tick();
    tick();
    chk("resume.disp_addr", 32'(disp_addr), 32'd10);
    chk("resume.disp_data", 32'(disp_data), 32'(mem(5'd10)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_read_sweeper.md
Name: ram_read_sweeper

Overview:
- Drives the read address of a ram32x4-style synchronous RAM.
- Advances the address on a programmable tick and waits out the RAM read latency.
- Latches each aligned (address, data) pair for the seg7 display stage.
- Sits upstream of the RAM's address input and downstream of its data output, on the same board clock as the metastability filters.

Parameters:
- ADDR_WIDTH, 5, read address width (RAM depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 4, RAM data width.
- TICK_COUNT, 50000000, clk cycles per address step (1 s at 50 MHz). Must be > READ_LATENCY + 1.
- READ_LATENCY, 2, clock edges from rd_addr change to valid rd_data. Must be >= 1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- rd_data  in  DATA_WIDTH  RAM read data.
- rd_addr  out  ADDR_WIDTH  RAM read address (registered).
- step  out  1  one-cycle pulse when rd_addr auto-advances.
- disp_addr  out  ADDR_WIDTH  address of the last captured word.
- disp_data  out  DATA_WIDTH  last captured RAM word.
- disp_valid  out  1  high once at least one capture has completed.

Interface decided: one clock (clk); reset is asynchronous and active-high (reset).

Behaviour:
- Reset (async, immediate): rd_addr=0, disp_addr=0, disp_data=0, disp_valid=0, step=0, divider=0, FSM=READ, latency counter=0.
- Edge numbering: the first rising edge after reset release is edge 1. Reset release counts as edge 0, at which rd_addr=0 is set.
- Divider:
  - Increments every edge.
  - At divider==TICK_COUNT-1: divider<=0, rd_addr<=rd_addr+1 (modulo 2**ADDR_WIDTH, so 31 wraps to 0), step<=1.
  - Otherwise step<=0. step is therefore high for exactly one cycle per advance.
- FSM states:
  - WAIT: idle. On any edge that changes rd_addr, go to READ with latency counter=1.
  - READ: latency counter increments each edge. On the edge where the counter reaches READ_LATENCY, sample rd_data into disp_data, copy the current rd_addr into disp_addr, set disp_valid<=1, and go to WAIT.
- Timing: for rd_addr set at edge E, capture occurs at edge E+READ_LATENCY. New disp values are visible in the cycle after that edge.
- Restart: if rd_addr changes while in READ, the latency counter restarts at 1 for the new address. A stale word is never captured under a new address.
- disp_valid stays 1 until the next reset.
- Reset mid-operation: all state returns to reset values immediately. The sweep restarts from address 0 with a fresh capture of address 0.
- No combinational path from rd_data to any output. All outputs are registered.

Optional Feature:
- Macro: SWEEP_MANUAL_EN.
- Defined:
  - Adds ports manual (in, 1) and manual_addr (in, ADDR_WIDTH), both pre-filtered by the caller.
  - While manual=1: divider is held at 0, step stays 0, and rd_addr<=manual_addr every edge.
  - Any resulting change of rd_addr triggers a capture exactly as an auto-step does (restart rules included).
  - On manual 1->0, auto sweep resumes from the current rd_addr with divider=0.
- Undefined: the ports do not exist and the sweep is purely automatic.

Test Plan (TICK_COUNT=4, READ_LATENCY=2; bench RAM model returns mem[addr] registered twice, mem[i]=i^4'hA):
- Reset release -> at edge 2, disp_addr=0, disp_data=4'hA, disp_valid=1; step=0 through edge 3.
- Free run -> step pulses after edges 4, 8, 12 (one cycle each); rd_addr goes 1, 2, 3; each capture arrives 2 edges after the step with disp_data=addr^4'hA.
- Wrap -> after 32 steps, rd_addr goes 31->0; disp_addr=31 with data 4'h5, then disp_addr=0 with data 4'hA.
- Reset asserted while in READ for address 7 -> outputs zero immediately, without waiting for clk; after release, the first capture is address 0 and no capture for address 7 ever appears.
- SWEEP_MANUAL_EN: manual=1, manual_addr 5 then 9 one edge apart -> no capture for 5; capture shows disp_addr=9, data 4'h3; step stays 0 for 20 cycles.
- SWEEP_MANUAL_EN: manual 1->0 at address 9 -> next step occurs 4 edges later and rd_addr becomes 10.
